// File: rtl/pid_math_pkg.sv
// Shared types and constants for the PID math sequencer: state encoding,
// ALU operand-select codes, gains and register widths.
package pid_math_pkg;

    localparam int A2D_W = 12;
    localparam int REG_W = 12;
    localparam int ACC_W = 16;
    localparam int DST_W = 16;
    localparam int SEL_W = 3;

    // Gains wired into the ALU beside the sequencer.
    localparam logic [13:0] PTERM = 14'h3680;
    localparam logic [11:0] ITERM = 12'h500;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ERR  = 3'd1,
        S_INTG = 3'd2,
        S_ICMP = 3'd3,
        S_PCMP = 3'd4,
        S_ACC1 = 3'd5,
        S_ACC2 = 3'd6,
        S_DONE = 3'd7
    } pid_state_e;

    localparam logic [SEL_W-1:0] SRC1_ACCUM     = 3'd0;
    localparam logic [SEL_W-1:0] SRC1_ITERM     = 3'd1;
    localparam logic [SEL_W-1:0] SRC1_ERR       = 3'd2;
    localparam logic [SEL_W-1:0] SRC1_ERR_DIV16 = 3'd3;
    localparam logic [SEL_W-1:0] SRC1_FWD       = 3'd4;
    localparam logic [SEL_W-1:0] SRC1_ZERO      = 3'd7;

    localparam logic [SEL_W-1:0] SRC0_A2D       = 3'd0;
    localparam logic [SEL_W-1:0] SRC0_INTGRL    = 3'd1;
    localparam logic [SEL_W-1:0] SRC0_ICOMP     = 3'd2;
    localparam logic [SEL_W-1:0] SRC0_PCOMP     = 3'd3;
    localparam logic [SEL_W-1:0] SRC0_PTERM     = 3'd4;
    localparam logic [SEL_W-1:0] SRC0_ZERO      = 3'd7;

    // Multiplier steps hold their controls for two cycles before capture.
    function automatic logic is_two_cycle(input pid_state_e s);
        return (s == S_ICMP) || (s == S_PCMP);
    endfunction

endpackage

// File: rtl/pid_math_seq.sv
// Six-step sequencer driving the PID math ALU once per sample.
// Optional integrator freeze: define PID_MATH_SEQ_INTG_HOLD_EN.
module pid_math_seq
    import pid_math_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [A2D_W-1:0]  A2D_res_in,
    input  logic [A2D_W-1:0]  Fwd_in,
    input  logic              intg_hold,
    input  logic [DST_W-1:0]  dst,
    output logic [SEL_W-1:0]  src1sel,
    output logic [SEL_W-1:0]  src0sel,
    output logic              multiply,
    output logic              sub,
    output logic              mult2,
    output logic              mult4,
    output logic              saturate,
    output logic [A2D_W-1:0]  A2D_res,
    output logic [A2D_W-1:0]  Fwd,
    output logic [REG_W-1:0]  Error,
    output logic [REG_W-1:0]  Intgrl,
    output logic [REG_W-1:0]  Icomp,
    output logic [ACC_W-1:0]  Pcomp,
    output logic [ACC_W-1:0]  Accum,
    output logic              busy,
    output logic              done,
    output pid_state_e        dbg_state
);

    // Handshake: start is a one-cycle request accepted only while the
    // state is IDLE; busy covers ERR..DONE and done marks Accum valid.

    pid_state_e state;
    logic       step_cnt;
    logic       step_last;

    assign step_last = !is_two_cycle(state) || step_cnt;
    assign dbg_state = state;

`ifndef PID_MATH_SEQ_INTG_HOLD_EN
    logic unused_intg_hold;
    assign unused_intg_hold = intg_hold;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            step_cnt <= 1'b0;
            A2D_res  <= '0;
            Fwd      <= '0;
            Error    <= '0;
            Intgrl   <= '0;
            Icomp    <= '0;
            Pcomp    <= '0;
            Accum    <= '0;
        end else if (state == S_IDLE) begin
            step_cnt <= 1'b0;
            if (start) begin
                A2D_res <= A2D_res_in;
                Fwd     <= Fwd_in;
                state   <= S_ERR;
            end
        end else if (!step_last) begin
            step_cnt <= 1'b1;
        end else begin
            step_cnt <= 1'b0;
            case (state)
                S_ERR: begin
                    Error <= dst[REG_W-1:0];
                    state <= S_INTG;
                end
                S_INTG: begin
`ifdef PID_MATH_SEQ_INTG_HOLD_EN
                    if (!intg_hold) begin
                        Intgrl <= dst[REG_W-1:0];
                    end
`else
                    Intgrl <= dst[REG_W-1:0];
`endif
                    state <= S_ICMP;
                end
                S_ICMP: begin
                    Icomp <= dst[REG_W-1:0];
                    state <= S_PCMP;
                end
                S_PCMP: begin
                    Pcomp <= dst;
                    state <= S_ACC1;
                end
                S_ACC1: begin
                    Accum <= dst;
                    state <= S_ACC2;
                end
                S_ACC2: begin
                    Accum <= dst;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        src1sel  = SRC1_ZERO;
        src0sel  = SRC0_ZERO;
        multiply = 1'b0;
        sub      = 1'b0;
        saturate = 1'b0;
        mult2    = 1'b0;
        mult4    = 1'b0;
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        case (state)
            S_ERR: begin
                src1sel  = SRC1_FWD;
                src0sel  = SRC0_A2D;
                sub      = 1'b1;
                saturate = 1'b1;
            end
            S_INTG: begin
                src1sel  = SRC1_ERR_DIV16;
                src0sel  = SRC0_INTGRL;
                saturate = 1'b1;
            end
            S_ICMP: begin
                src1sel  = SRC1_ITERM;
                src0sel  = SRC0_INTGRL;
                multiply = 1'b1;
            end
            S_PCMP: begin
                src1sel  = SRC1_ERR;
                src0sel  = SRC0_PTERM;
                multiply = 1'b1;
            end
            S_ACC1: begin
                // Unsaturated so the final subtract sees the full 16-bit value.
                src1sel  = SRC1_FWD;
                src0sel  = SRC0_PCOMP;
                sub      = 1'b1;
            end
            S_ACC2: begin
                src1sel  = SRC1_ACCUM;
                src0sel  = SRC0_ICOMP;
                sub      = 1'b1;
                saturate = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
